// File: rtl/banco_registradores.sv
// Register file for the single-cycle MIPS datapath: two combinational read ports, a debug
// read port and one synchronous write port. Optional write-first bypass: BANCO_BYPASS_EN.
module banco_registradores #(
    parameter int unsigned         LARGURA    = 32,
    parameter int unsigned         NUM_REGS   = 32,
    parameter int unsigned         END_W      = 5,
    parameter logic [LARGURA-1:0]  GP_INICIAL = 32'h1000_8000,
    parameter logic [LARGURA-1:0]  SP_INICIAL = 32'h7FFF_EFFC
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               regEscrita,
    input  logic [END_W-1:0]   escreveReg,
    input  logic [LARGURA-1:0] dadoEscrita,
    input  logic [END_W-1:0]   leReg1,
    input  logic [END_W-1:0]   leReg2,
    input  logic [END_W-1:0]   regDebug,
    output logic [LARGURA-1:0] dados1,
    output logic [LARGURA-1:0] dados2,
    output logic [LARGURA-1:0] dadoDebug,
    output logic [15:0]        escritas
);

    logic [LARGURA-1:0] regs [NUM_REGS];
    logic               escreve;
    logic [15:0]        escritas_q;
    logic [15:0]        escritas_d;

    // Writes to $zero are dropped entirely, including from the write counter.
    assign escreve = regEscrita && (escreveReg != '0);

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_reg
        if (g == 0) begin : g_zero
            assign regs[g] = '0;
        end else begin : g_store
            localparam logic [LARGURA-1:0] ValorReset = (g == 28) ? GP_INICIAL :
                                                        (g == 29) ? SP_INICIAL : '0;
            logic [LARGURA-1:0] reg_q;

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    reg_q <= ValorReset;
                end else if (escreve && (escreveReg == END_W'(g))) begin
                    reg_q <= dadoEscrita;
                end
            end

            assign regs[g] = reg_q;
        end
    end

    always_comb begin
        escritas_d = escritas_q;
        if (escreve && (escritas_q != 16'hFFFF)) begin
            escritas_d = escritas_q + 16'd1;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            escritas_q <= '0;
        end else begin
            escritas_q <= escritas_d;
        end
    end

    assign escritas = escritas_q;

`ifdef BANCO_BYPASS_EN
    assign dados1    = (escreve && (escreveReg == leReg1))   ? dadoEscrita : regs[leReg1];
    assign dados2    = (escreve && (escreveReg == leReg2))   ? dadoEscrita : regs[leReg2];
    assign dadoDebug = (escreve && (escreveReg == regDebug)) ? dadoEscrita : regs[regDebug];
`else
    assign dados1    = regs[leReg1];
    assign dados2    = regs[leReg2];
    assign dadoDebug = regs[regDebug];
`endif

endmodule
